// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq
// Sequential four-digit BCD to binary converter using reverse double-dabble.
//
// A (16+N)-bit working register is loaded with the BCD digits in its upper 16
// bits. It is then shifted right once per cycle for N cycles. After every shift,
// 3 is subtracted from each BCD nibble that reads 8 or more. When the N shifts
// are complete, the low N bits hold the binary value.
//
// Timing: start sampled at edge k gives a one-cycle done pulse in the cycle after
// edge k+N+1. Bin is loaded on the same edge that raises done, and Bin holds its
// value until the next done pulse.
//
// Optional feature: define BCD_DIGIT_CHECK_EN to compile in digit validation.
// A captured digit above 9 then skips the shift phase. The result is Bin=0 with
// err=1, and done arrives one edge after the start edge. Without the macro, err
// is tied low. Invalid digits are shifted like any others, and the result for
// them is not meaningful.

module bcd_to_binary_seq #(
    parameter int N = 14
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [3:0]   I0,
    input  logic [3:0]   I1,
    input  logic [3:0]   I2,
    input  logic [3:0]   I3,
    output logic [N-1:0] Bin,
    output logic         busy,
    output logic         done,
    output logic         err
);

    localparam int W  = 16 + N;
    localparam int CW = $clog2(N + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   work_q, work_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   bin_q, bin_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic [15:0]    digits_in;
    logic [W-1:0]   load_value;
    logic [W-1:0]   shifted;
    logic [15:0]    fixed_bcd;
    logic [W-1:0]   shift_next;
    logic           start_ok;
    logic           last_shift;

`ifdef BCD_DIGIT_CHECK_EN
    logic           err_q, err_d;
    logic           bad_q, bad_d;
    logic           digit_bad;
`endif

    assign digits_in  = {I3, I2, I1, I0};
    assign load_value = {digits_in, {N{1'b0}}};

    // Start is honoured only when idle and not in the done-pulse cycle, so a
    // start held across the completion cannot slip in on the strobe itself.
    assign start_ok   = start && !done_q;

    // Last shift happens when the counter has already seen N-1 shifts.
    assign last_shift = (cnt_q == CW'(N - 1));

    // Shift step: move right by one, then correct every BCD nibble reading >= 8.
    assign shifted = work_q >> 1;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bcd_fix
        logic [3:0] nib;
        assign nib = shifted[N + 4*gi +: 4];
        assign fixed_bcd[4*gi +: 4] = (nib >= 4'd8) ? (nib - 4'd3) : nib;
    end

    assign shift_next = {fixed_bcd, shifted[N-1:0]};

`ifdef BCD_DIGIT_CHECK_EN
    // Any digit above 9 marks the request invalid.
    logic [3:0] digit_over;
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit_chk
        assign digit_over[gi] = (digits_in[4*gi +: 4] > 4'd9);
    end
    assign digit_bad = |digit_over;
`endif

    // Next-state, datapath and output-register logic.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        done_d  = 1'b0;
`ifdef BCD_DIGIT_CHECK_EN
        err_d   = 1'b0;
        bad_d   = bad_q;
`endif
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    work_d = load_value;
                    cnt_d  = '0;
`ifdef BCD_DIGIT_CHECK_EN
                    bad_d   = digit_bad;
                    state_d = digit_bad ? FIN : SHIFT;
`else
                    state_d = SHIFT;
`endif
                end
            end
            SHIFT: begin
                work_d = shift_next;
                cnt_d  = cnt_q + 1'b1;
                if (last_shift) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                done_d  = 1'b1;
                state_d = IDLE;
`ifdef BCD_DIGIT_CHECK_EN
                err_d = bad_q;
                bad_d = 1'b0;
                bin_d = bad_q ? '0 : work_q[N-1:0];
`else
                bin_d = work_q[N-1:0];
`endif
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            bin_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

`ifdef BCD_DIGIT_CHECK_EN
    // Digit-validation flags, cleared by the same reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_q <= 1'b0;
            bad_q <= 1'b0;
        end else begin
            err_q <= err_d;
            bad_q <= bad_d;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    assign Bin  = bin_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule
